fmap_banked_mem: RTL

Next-generation feature-map scratchpad for the CNN/FC MAC array. It replaces the single flat array with NUM_BANKS low-order-interleaved banks. Each port has a valid/ready handshake, and each bank has round-robin arbitration with broadcast of identical read addresses. A hardware clear sweep replaces the single-cycle full-array reset. It sits between the MAC columns (ofmap writes, partial-sum reads) and the MAC inputs (ifmap reads).

---
 rtl/fmap_mem_pkg.sv | 20 ++
 rtl/fmap_banked_mem_if.sv | 23 ++
 rtl/fmap_banked_mem_rr_arbiter.sv | 29 ++
 rtl/fmap_banked_mem.sv | 103 ++++++++++
 4 files changed

// File: rtl/fmap_mem_pkg.sv
// fmap_mem_pkg: sizing, FSM states and address split shared by fmap_banked_mem
package fmap_mem_pkg;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int NUM_BANKS = 4;
    localparam int N_RD      = 6;
    localparam int N_WR      = 4;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int ROW_W     = ADDR_W - BANK_W;
    typedef enum logic {CLEAR, IDLE} state_t;
    // low-order interleave: bank from the bottom bits, row from the rest
    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return BANK_W'(addr);
    endfunction
    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
        return ROW_W'(addr >> BANK_W);
    endfunction
endpackage

// File: rtl/fmap_banked_mem_if.sv
// fmap_banked_mem_if: read, write and clear port bundle of fmap_banked_mem
interface fmap_banked_mem_if;
    import fmap_mem_pkg::*;
    logic                         clr_req;
    logic                         clr_busy;
    logic [N_RD-1:0]              rd_valid;
    logic [N_RD-1:0][ADDR_W-1:0]  rd_addr;
    logic [N_RD-1:0]              rd_ready;
    logic [N_RD-1:0][DATA_W-1:0]  rd_data;
    logic [N_RD-1:0]              rd_data_valid;
    logic [N_WR-1:0]              wr_valid;
    logic [N_WR-1:0][ADDR_W-1:0]  wr_addr;
    logic [N_WR-1:0][DATA_W-1:0]  wr_data;
    logic [N_WR-1:0]              wr_ready;
    modport master (
        output clr_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  clr_busy, rd_ready, rd_data, rd_data_valid, wr_ready
    );
    modport slave (
        input  clr_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output clr_busy, rd_ready, rd_data, rd_data_valid, wr_ready
    );
endinterface

// File: rtl/fmap_banked_mem_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves past the winner on every grant
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr, nxt, idx;
    // scan from the farthest candidate back to ptr so the nearest requester wins
    always_comb begin
        gnt = '0;
        nxt = ptr;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
                nxt = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
            end
        end
    end
    always_ff @(posedge clk)
        if (rst) ptr <= '0;
        else if (|req) ptr <= nxt;
endmodule

// File: rtl/fmap_banked_mem.sv
// fmap_banked_mem: NUM_BANKS-way interleaved fmap scratchpad with per-bank RR arbitration and clear sweep.
// FMAP_MEM_WR_BYPASS_EN: a read granted alongside a write to the same address returns the new data.
module fmap_banked_mem
    import fmap_mem_pkg::*;
(
    input logic              clk,
    input logic              rst,
    fmap_banked_mem_if.slave bus
);
    state_t                           state, state_nxt;
    logic [ROW_W-1:0]                 cnt, cnt_nxt;
    logic                             idle;
    logic [NUM_BANKS-1:0][N_RD-1:0]   rreq, rgnt;
    logic [NUM_BANKS-1:0][N_WR-1:0]   wreq, wgnt;
    logic [NUM_BANKS-1:0][ADDR_W-1:0] rwin, wwin;
    logic [NUM_BANKS-1:0][DATA_W-1:0] wdat;
    logic [NUM_BANKS-1:0]             wen;
    logic [N_RD-1:0]                  rd_ready, rd_dv;
    logic [N_WR-1:0]                  wr_ready;
    logic [N_RD-1:0][DATA_W-1:0]      rword, rd_dq;
    logic [DATA_W-1:0]                mem [NUM_BANKS][ROWS];

    always_ff @(posedge clk)
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    // the row counter wraps to 0 on the last clear row, ready for the next sweep
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (state == CLEAR) begin
            cnt_nxt   = cnt + ROW_W'(1);
            state_nxt = (cnt == ROW_W'(ROWS - 1)) ? IDLE : CLEAR;
        end else if (bus.clr_req) state_nxt = CLEAR;
    end

    assign idle = (state == IDLE) && !rst;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar p = 0; p < N_RD; p++) begin : g_rd
            assign rreq[b][p] = idle && bus.rd_valid[p] && bank_of(bus.rd_addr[p]) == BANK_W'(b);
        end
        for (genvar w = 0; w < N_WR; w++) begin : g_wr
            assign wreq[b][w] = idle && bus.wr_valid[w] && bank_of(bus.wr_addr[w]) == BANK_W'(b);
        end
        rr_arbiter #(.N(N_RD)) u_rd_arb (.clk(clk), .rst(rst), .req(rreq[b]), .gnt(rgnt[b]));
        rr_arbiter #(.N(N_WR)) u_wr_arb (.clk(clk), .rst(rst), .req(wreq[b]), .gnt(wgnt[b]));
    end

    // every requester sharing the winner's address rides along on the same bank read
    always_comb begin
        rwin     = '0;
        wwin     = '0;
        wdat     = '0;
        wen      = '0;
        rd_ready = '0;
        wr_ready = '0;
        rword    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < N_RD; p++) if (rgnt[b][p]) rwin[b] = bus.rd_addr[p];
            for (int p = 0; p < N_RD; p++) if (rreq[b][p] && bus.rd_addr[p] == rwin[b]) rd_ready[p] = 1'b1;
            for (int w = 0; w < N_WR; w++)
                if (wgnt[b][w]) begin
                    wwin[b]     = bus.wr_addr[w];
                    wdat[b]     = bus.wr_data[w];
                    wen[b]      = 1'b1;
                    wr_ready[w] = 1'b1;
                end
        end
        for (int p = 0; p < N_RD; p++) begin
            rword[p] = mem[bank_of(bus.rd_addr[p])][row_of(bus.rd_addr[p])];
`ifdef FMAP_MEM_WR_BYPASS_EN
            if (wen[bank_of(bus.rd_addr[p])] && wwin[bank_of(bus.rd_addr[p])] == bus.rd_addr[p])
                rword[p] = wdat[bank_of(bus.rd_addr[p])];
`endif
        end
    end

    always_ff @(posedge clk)
        for (int b = 0; b < NUM_BANKS; b++)
            if (state == CLEAR) mem[b][cnt] <= '0;
            else if (wen[b]) mem[b][row_of(wwin[b])] <= wdat[b];

    always_ff @(posedge clk)
        if (rst) begin
            rd_dq <= '0;
            rd_dv <= '0;
        end else begin
            rd_dv <= rd_ready;
            for (int p = 0; p < N_RD; p++) if (rd_ready[p]) rd_dq[p] <= rword[p];
        end

    assign bus.clr_busy      = (state == CLEAR);
    assign bus.rd_ready      = rd_ready;
    assign bus.wr_ready      = wr_ready;
    assign bus.rd_data       = rd_dq;
    assign bus.rd_data_valid = rd_dv;
endmodule
